// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling FSM with false-start
// rejection, parity/framing checks and a valid/ready holding register with overrun detection.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 6_250_000,
  parameter int unsigned BAUD_RATE = 128000,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 new_data_toggle
);

  localparam int unsigned Div    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned Half   = Div / 2;
  localparam int unsigned CntW   = $clog2(Div);
  localparam int unsigned BidxW  = 4;
  localparam logic        ParOdd = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkwait
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BidxW-1:0]      bidx_q, bidx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  ferr_q, ferr_d;
  logic                  rxd_meta_q, rxd_s;

  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_out_q, ferr_out_d;
  logic                  overrun_q, overrun_d;
  logic                  toggle_q, toggle_d;

  logic                  bit_end;
  logic                  frame_done;
  logic                  frame_ferr;
  logic                  frame_perr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_s      <= rxd_meta_q;
    end
  end

  assign bit_end    = (cnt_q == CntW'(Div - 1));
  assign frame_perr = (PARITY != 0) && (((^shreg_q) ^ par_q) != ParOdd);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    frame_ferr = ferr_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bidx_d = '0;
        ferr_d = 1'b0;
        if (!rxd_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntW'(Half - 1)) begin
          cnt_d   = '0;
          bidx_d  = '0;
          state_d = rxd_s ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          // LSB arrives first, so after DATA_BITS right-shifts it sits in bit 0
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + BidxW'(1);
          if (bidx_q == BidxW'(DATA_BITS - 1)) begin
            bidx_d  = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d      = '0;
          frame_ferr = ferr_q | ~rxd_s;
          ferr_d     = frame_ferr;
          bidx_d     = bidx_q + BidxW'(1);
          if (bidx_q == BidxW'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_d    = frame_ferr ? StBrkwait : StIdle;
          end
        end
      end
      StBrkwait: begin
        // A held-low (break) line must not look like a new start bit
        cnt_d = '0;
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    toggle_d   = toggle_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        perr_d     = frame_perr;
        ferr_out_d = frame_ferr;
        rx_valid_d = 1'b1;
        toggle_d   = ~toggle_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
      toggle_q   <= toggle_d;
    end
  end

  assign rx_data         = rx_data_q;
  assign rx_valid        = rx_valid_q;
  assign parity_err      = perr_q;
  assign frame_err       = ferr_out_q;
  assign overrun         = overrun_q;
  assign new_data_toggle = toggle_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 instance plus an even-parity instance.
module tb_uart_rx_param;

  localparam int DIV = 48;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rxd_p;
  logic       rx_ready;

  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, rx_valid_p;
  logic       parity_err, parity_err_p;
  logic       frame_err, frame_err_p;
  logic       overrun, overrun_p;
  logic       toggle, toggle_p;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ocnt = 0;
  int lcnt = 0;
  logic tog_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .clk             (clk),
    .reset           (reset),
    .RxD             (rxd),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .new_data_toggle (toggle)
  );

  uart_rx_param #(.PARITY(1)) dut_p (
    .clk             (clk),
    .reset           (reset),
    .RxD             (rxd_p),
    .rx_data         (rx_data_p),
    .rx_valid        (rx_valid_p),
    .rx_ready        (rx_ready),
    .parity_err      (parity_err_p),
    .frame_err       (frame_err_p),
    .overrun         (overrun_p),
    .new_data_toggle (toggle_p)
  );

  // Observe the default instance away from the active edge
  always @(negedge clk) begin
    if (rx_valid) vcnt++;
    if (overrun) ocnt++;
    if (toggle != tog_prev) lcnt++;
    tog_prev = toggle;
  end

  task automatic drive_bit(input bit on_p, input logic v);
    if (on_p) rxd_p = v;
    else rxd = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input bit on_p, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stopb);
    @(negedge clk);
    drive_bit(on_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(on_p, d[i]);
    if (use_par) drive_bit(on_p, pbit);
    drive_bit(on_p, stopb);
    if (on_p) rxd_p = 1'b1;
    else rxd = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rxd = 1'b1; rxd_p = 1'b1; rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
    checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL reset_tog got %b want 0", toggle); end
    checks++; if (rx_valid_p !== 1'b0) begin errors++; $display("FAIL reset_valid_p got %b want 0", rx_valid_p); end
    reset = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0, l0;
    v0 = vcnt; l0 = lcnt;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL t1_data got %h want a5", rx_data); end
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL t1_valid_cycles got %0d want 1", vcnt - v0); end
    checks++; if (lcnt - l0 !== 1) begin errors++; $display("FAIL t1_toggle_flips got %0d want 1", lcnt - l0); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL t1_perr got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t1_ferr got %b want 0", frame_err); end
  endtask

  task automatic test_false_start();
    int v0;
    v0 = vcnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL t2_no_output got %0d want %0d", vcnt, v0); end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL t2_data got %h want 3c", rx_data); end
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL t2_valid_cycles got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_parity();
    // 0x37 has five ones, so the correct even parity bit is 1
    send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data_p !== 8'h37) begin errors++; $display("FAIL t3_data got %h want 37", rx_data_p); end
    checks++; if (parity_err_p !== 1'b1) begin errors++; $display("FAIL t3_perr_bad got %b want 1", parity_err_p); end
    checks++; if (frame_err_p !== 1'b0) begin errors++; $display("FAIL t3_ferr got %b want 0", frame_err_p); end
    send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (parity_err_p !== 1'b0) begin errors++; $display("FAIL t3_perr_good got %b want 0", parity_err_p); end
  endtask

  task automatic test_frame_err();
    int l0;
    l0 = lcnt;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL t4_ferr got %b want 1", frame_err); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL t4_data got %h want 55", rx_data); end
    checks++; if (lcnt - l0 !== 1) begin errors++; $display("FAIL t4_loads got %0d want 1", lcnt - l0); end
    rxd = 1'b1;
    repeat (DIV) @(negedge clk);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL t4_next_data got %h want 81", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t4_next_ferr got %b want 0", frame_err); end
    checks++; if (lcnt - l0 !== 2) begin errors++; $display("FAIL t4_total_loads got %0d want 2", lcnt - l0); end
  endtask

  task automatic test_back_to_back();
    int o0, l0;
    o0 = ocnt; l0 = lcnt;
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL t5_held_data got %h want 11", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL t5_valid_held got %b want 1", rx_valid); end
    checks++; if (ocnt - o0 !== 1) begin errors++; $display("FAIL t5_overrun_cycles got %0d want 1", ocnt - o0); end
    checks++; if (lcnt - l0 !== 1) begin errors++; $display("FAIL t5_loads got %0d want 1", lcnt - l0); end
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_drop got %b want 0", rx_valid); end
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL t5_third_data got %h want 33", rx_data); end
  endtask

  task automatic test_reset_mid();
    int v0, l0;
    // Start bit, then abort during the low nibble of 0xF0
    @(negedge clk);
    drive_bit(1'b0, 1'b0);
    repeat (DIV + DIV / 2) @(negedge clk);
    reset = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL t6_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t6_ferr got %b want 0", frame_err); end
    checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL t6_tog got %b want 0", toggle); end
    reset = 1'b1;
    v0 = vcnt;
    repeat (2 * DIV) @(negedge clk);
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL t6_abandoned got %0d want %0d", vcnt, v0); end
    l0 = lcnt;
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL t6_next_data got %h want 0f", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL t6_perr got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t6_next_ferr got %b want 0", frame_err); end
    checks++; if (toggle !== 1'b1) begin errors++; $display("FAIL t6_next_tog got %b want 1", toggle); end
    checks++; if (lcnt - l0 !== 1) begin errors++; $display("FAIL t6_loads got %0d want 1", lcnt - l0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
